// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and drives the nPC register's load value
// and enable. It implements PC/nPC delayed control transfer with SPARC-style
// annulment of the delay slot.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   stall           hold pc/state this cycle; nPC is not loaded
//   cti_valid       instruction at pc is a control-transfer instruction
//   cti_taken       CTI resolved taken (qualified by cti_valid)
//   cti_uncond      CTI is unconditional (ba/call/jmpl)
//   cti_annul       annul bit of the CTI
//   cti_target      CTI target address (low two bits ignored)
//   trap_valid      redirect fetch to trap_vector
//   trap_vector     trap target (low two bits ignored)
//   npc_q           current nPC register value
//   pc              fetch address (registered)
//   npc_d           next nPC register value (combinational)
//   npc_le          nPC register load enable (combinational)
//   fetch_annul     instruction at pc is a squashed delay slot (registered)
//   in_dslot        instruction at pc is a delay slot (registered)
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        cti_valid,
    input  logic        cti_taken,
    input  logic        cti_uncond,
    input  logic        cti_annul,
    input  logic [31:0] cti_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_vector,
    input  logic [31:0] npc_q,
    output logic [31:0] pc,
    output logic [31:0] npc_d,
    output logic        npc_le,
    output logic        fetch_annul,
    output logic        in_dslot
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DSLOT = 2'd1,
        ANNUL = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] pc_nx;
    logic [AW-1:0] target_al;
    logic [AW-1:0] vector_al;
    logic [AW-1:0] npc_inc;
    logic          annul_slot;
    logic          unused_addr_lsbs;

    // Word-align redirect addresses; the dropped bits are intentionally unused.
    assign target_al        = {cti_target[AW-1:2], 2'b00};
    assign vector_al        = {trap_vector[AW-1:2], 2'b00};
    assign unused_addr_lsbs = ^{cti_target[1:0], trap_vector[1:0]};
    assign npc_inc          = npc_q + AW'(4);

    // Delay slot is squashed for an untaken annulling branch, or for ba,a.
    assign annul_slot = (cti_annul && !cti_taken) ||
                        (cti_annul && cti_uncond && cti_taken);

    // State register; pc and status flags advance with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_annul <= 1'b0;
            in_dslot    <= 1'b0;
        end else if (!stall) begin
            state       <= state_nx;
            pc          <= pc_nx;
            fetch_annul <= (state_nx == ANNUL);
            in_dslot    <= (state_nx != RUN);
        end
    end

    // Next state and next fetch address, highest priority first.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        if (trap_valid) begin
            state_nx = RUN;
            pc_nx    = vector_al;
        end else if (state == ANNUL) begin
            // A squashed instruction cannot transfer control.
            state_nx = RUN;
            pc_nx    = npc_q;
        end else if (cti_valid) begin
            state_nx = annul_slot ? ANNUL : DSLOT;
            pc_nx    = npc_q;
        end else begin
            state_nx = RUN;
            pc_nx    = npc_q;
        end
    end

    // nPC load value and enable.
    always_comb begin
        npc_d  = npc_inc;
        npc_le = !stall && !reset;
        if (!stall && !reset) begin
            if (trap_valid) begin
                npc_d = vector_al + AW'(4);
            end else if (state != ANNUL && cti_valid && cti_taken) begin
                npc_d = target_al;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        cti_valid;
    logic        cti_taken;
    logic        cti_uncond;
    logic        cti_annul;
    logic [31:0] cti_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic [31:0] npc_q;
    logic [31:0] pc;
    logic [31:0] npc_d;
    logic        npc_le;
    logic        fetch_annul;
    logic        in_dslot;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_npc;
    bit          m_annulled;
    bit          m_dslot;
    bit          m_valid = 1'b0;

    pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .cti_valid  (cti_valid),
        .cti_taken  (cti_taken),
        .cti_uncond (cti_uncond),
        .cti_annul  (cti_annul),
        .cti_target (cti_target),
        .trap_valid (trap_valid),
        .trap_vector(trap_vector),
        .npc_q      (npc_q),
        .pc         (pc),
        .npc_d      (npc_d),
        .npc_le     (npc_le),
        .fetch_annul(fetch_annul),
        .in_dslot   (in_dslot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The downstream nPC register
    always_ff @(posedge clk) begin
        if (reset)       npc_q <= RESET_PC + 32'd4;
        else if (npc_le) npc_q <= npc_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check against model mid-cycle, advance model, clock.
    task automatic step(input logic rst, input logic stl, input logic cv, input logic ct,
                        input logic cu, input logic ca, input logic [31:0] tgt,
                        input logic tv, input logic [31:0] vec);
        logic [31:0] t_al;
        logic [31:0] v_al;
        logic [31:0] e_npc_d;
        logic [31:0] nn;
        reset = rst; stall = stl; cti_valid = cv; cti_taken = ct; cti_uncond = cu;
        cti_annul = ca; cti_target = tgt; trap_valid = tv; trap_vector = vec;
        #4;
        t_al = tgt & 32'hFFFF_FFFC;
        v_al = vec & 32'hFFFF_FFFC;
        chk("npc_le", 32'(npc_le), 32'(!rst && !stl));
        if (m_valid) begin
            e_npc_d = m_npc + 32'd4;
            if (!rst && !stl) begin
                if (tv)                          e_npc_d = v_al + 32'd4;
                else if (!m_annulled && cv && ct) e_npc_d = t_al;
            end
            chk("pc", pc, m_pc);
            chk("npc_q", npc_q, m_npc);
            chk("npc_d", npc_d, e_npc_d);
            chk("fetch_annul", 32'(fetch_annul), 32'(m_annulled));
            chk("in_dslot", 32'(in_dslot), 32'(m_dslot));
        end
        if (rst) begin
            m_pc = RESET_PC; m_npc = RESET_PC + 32'd4;
            m_annulled = 1'b0; m_dslot = 1'b0; m_valid = 1'b1;
        end else if (stl) begin
            // everything holds
        end else if (tv) begin
            m_pc = v_al; m_npc = v_al + 32'd4; m_annulled = 1'b0; m_dslot = 1'b0;
        end else if (m_annulled || !cv) begin
            m_pc = m_npc; m_npc = m_npc + 32'd4; m_annulled = 1'b0; m_dslot = 1'b0;
        end else begin
            nn = ct ? t_al : m_npc + 32'd4;
            m_pc = m_npc; m_npc = nn;
            m_dslot = 1'b1;
            m_annulled = ca && (!ct || cu);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic free();
        step(0, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; cti_valid = 1'b0; cti_taken = 1'b0;
        cti_uncond = 1'b0; cti_annul = 1'b0; cti_target = '0;
        trap_valid = 1'b0; trap_vector = '0;
        @(posedge clk); #1;

        // Reset and sequential fetch
        step(1, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_annul", 32'(fetch_annul), 32'd0);
        free(); chk("seq_pc4", pc, 32'h4);
        free(); chk("seq_pc8", pc, 32'h8);
        free(); chk("seq_pc12", pc, 32'hC);
        free(); chk("seq_pc16", pc, 32'h10);

        // Taken conditional CTI, no annul
        step(0, 0, 1, 1, 0, 0, 32'h100, 0, 32'd0);
        chk("tk_dslot_pc", pc, 32'h14);
        chk("tk_dslot", 32'(in_dslot), 32'd1);
        free(); chk("tk_target", pc, 32'h100);

        // Move to 0x20, untaken annulling CTI; CTI in squashed slot ignored
        step(0, 0, 0, 0, 0, 0, 32'd0, 1, 32'h20);
        chk("trap_pc20", pc, 32'h20);
        step(0, 0, 1, 0, 0, 1, 32'h400, 0, 32'd0);
        chk("unt_pc", pc, 32'h24);
        chk("unt_annul", 32'(fetch_annul), 32'd1);
        step(0, 0, 1, 1, 1, 0, 32'h500, 0, 32'd0);
        chk("ign_pc", pc, 32'h28);
        chk("ign_annul", 32'(fetch_annul), 32'd0);

        // ba,a
        step(0, 0, 1, 1, 1, 1, 32'h200, 0, 32'd0);
        chk("baa_pc", pc, 32'h2C);
        chk("baa_annul", 32'(fetch_annul), 32'd1);
        free(); chk("baa_target", pc, 32'h200);

        // Stall in DSLOT, with a trap during the stall
        step(0, 0, 1, 1, 0, 0, 32'h300, 0, 32'd0);
        chk("st_dslot_pc", pc, 32'h204);
        step(0, 1, 0, 0, 0, 0, 32'd0, 0, 32'd0);
        step(0, 1, 0, 0, 0, 0, 32'd0, 1, 32'h40);
        chk("st_hold_pc", pc, 32'h204);
        chk("st_hold_ds", 32'(in_dslot), 32'd1);
        free(); chk("st_release", pc, 32'h300);

        // Trap in ANNUL
        step(0, 0, 1, 0, 0, 1, 32'h900, 0, 32'd0);
        chk("an_pc", pc, 32'h304);
        step(0, 0, 0, 0, 0, 0, 32'd0, 1, 32'h8000_0003);
        chk("trap_pc", pc, 32'h8000_0000);
        chk("trap_annul", 32'(fetch_annul), 32'd0);
        chk("trap_ds", 32'(in_dslot), 32'd0);

        // Address wrap
        step(0, 0, 0, 0, 0, 0, 32'd0, 1, 32'hFFFF_FFF8);
        chk("wr_pc0", pc, 32'hFFFF_FFF8);
        free(); chk("wr_pc1", pc, 32'hFFFF_FFFC);
        free(); chk("wr_pc2", pc, 32'h0);
        free(); chk("wr_pc3", pc, 32'h4);

        // Reset mid delay slot with a trap present; no target survives
        step(0, 0, 1, 1, 0, 0, 32'h700, 0, 32'd0);
        chk("mr_ds", 32'(in_dslot), 32'd1);
        step(1, 0, 0, 0, 0, 0, 32'd0, 1, 32'h600);
        chk("mr_pc", pc, RESET_PC);
        chk("mr_ds0", 32'(in_dslot), 32'd0);
        free(); chk("mr_next", pc, RESET_PC + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 19) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
